// File: rtl/battle_front_scanner.sv
// Serially scans friendly and enemy unit slots for the nearest fronts, then applies safety offsets.
// Optional feature macro BATTLE_FRONT_SAT_EN: when defined, the offsets saturate instead of wrapping.
module battle_front_scanner #(
    parameter  int NUM_SLOTS       = 16,
    parameter  int LOC_W           = 9,
    parameter  int TYPE_W          = 2,
    parameter  int FRIENDLY_OFFSET = 6,
    parameter  int ENEMY_OFFSET    = 7,
    localparam int IDX_W           = $clog2(NUM_SLOTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Start,
    input  logic                        Ack,
    input  logic [NUM_SLOTS*LOC_W-1:0]  unitLoc,
    input  logic [NUM_SLOTS*TYPE_W-1:0] unitType,
    input  logic [NUM_SLOTS*LOC_W-1:0]  enemyLoc,
    input  logic [NUM_SLOTS*TYPE_W-1:0] enemyType,
    output logic [LOC_W-1:0]            friendlyFront,
    output logic [LOC_W-1:0]            enemyFront,
    output logic [IDX_W-1:0]            friendlyIdx,
    output logic [IDX_W-1:0]            enemyIdx,
    output logic                        friendlyValid,
    output logic                        enemyValid,
    output logic                        Busy,
    output logic                        Done
);
    typedef enum logic [3:0] {
        S_INITIAL = 4'b0001,
        S_SCAN    = 4'b0010,
        S_ADJUST  = 4'b0100,
        S_DONE    = 4'b1000
    } state_t;

    localparam logic [LOC_W-1:0] LOC_MAX  = {LOC_W{1'b1}};
    localparam logic [LOC_W-1:0] LOC_ZERO = {LOC_W{1'b0}};
    localparam logic [LOC_W-1:0] F_OFF    = LOC_W'(FRIENDLY_OFFSET);
    localparam logic [LOC_W-1:0] E_OFF    = LOC_W'(ENEMY_OFFSET);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_i, w_i_nxt;
    logic [LOC_W-1:0] r_f_loc, w_f_loc_nxt, r_e_loc, w_e_loc_nxt;
    logic [IDX_W-1:0] r_f_idx, w_f_idx_nxt, r_e_idx, w_e_idx_nxt;
    logic             r_f_vld, w_f_vld_nxt, r_e_vld, w_e_vld_nxt;

    logic [LOC_W-1:0] w_slot_uloc, w_slot_eloc;
    logic             w_slot_uocc, w_slot_eocc;
    logic [LOC_W:0]   w_f_diff, w_e_sum;
    logic [LOC_W-1:0] w_f_adj, w_e_adj;

    assign w_slot_uloc = unitLoc[int'(r_i)*LOC_W +: LOC_W];
    assign w_slot_eloc = enemyLoc[int'(r_i)*LOC_W +: LOC_W];
    assign w_slot_uocc = |unitType[int'(r_i)*TYPE_W +: TYPE_W];
    assign w_slot_eocc = |enemyType[int'(r_i)*TYPE_W +: TYPE_W];

    // The extra top bit of each result flags borrow/carry out of the location range
    assign w_f_diff = {1'b0, r_f_loc} - {1'b0, F_OFF};
    assign w_e_sum  = {1'b0, r_e_loc} + {1'b0, E_OFF};
`ifdef BATTLE_FRONT_SAT_EN
    assign w_f_adj  = w_f_diff[LOC_W] ? LOC_ZERO : w_f_diff[LOC_W-1:0];
    assign w_e_adj  = w_e_sum[LOC_W]  ? LOC_MAX  : w_e_sum[LOC_W-1:0];
`else
    assign w_f_adj  = w_f_diff[LOC_W-1:0];
    assign w_e_adj  = w_e_sum[LOC_W-1:0];
`endif

    // Next-state and datapath update for the seed/scan/adjust sequence
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_f_loc_nxt = r_f_loc;
        w_e_loc_nxt = r_e_loc;
        w_f_idx_nxt = r_f_idx;
        w_e_idx_nxt = r_e_idx;
        w_f_vld_nxt = r_f_vld;
        w_e_vld_nxt = r_e_vld;
        case (r_state)
            S_INITIAL: begin
                if (Start) begin
                    w_state_nxt = S_SCAN;
                    w_i_nxt     = IDX_ONE;
                    w_f_idx_nxt = IDX_ZERO;
                    w_e_idx_nxt = IDX_ZERO;
                    if (|unitType[TYPE_W-1:0]) begin
                        w_f_loc_nxt = unitLoc[LOC_W-1:0];
                        w_f_vld_nxt = 1'b1;
                    end else begin
                        w_f_loc_nxt = LOC_MAX;
                        w_f_vld_nxt = 1'b0;
                    end
                    if (|enemyType[TYPE_W-1:0]) begin
                        w_e_loc_nxt = enemyLoc[LOC_W-1:0];
                        w_e_vld_nxt = 1'b1;
                    end else begin
                        w_e_loc_nxt = LOC_ZERO;
                        w_e_vld_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = S_INITIAL;
                end
            end
            S_SCAN: begin
                // Strict compare keeps the lowest index on ties; an unseeded side takes the first occupant
                if (w_slot_uocc && (!r_f_vld || (w_slot_uloc < r_f_loc))) begin
                    w_f_loc_nxt = w_slot_uloc;
                    w_f_idx_nxt = r_i;
                    w_f_vld_nxt = 1'b1;
                end else begin
                    w_f_vld_nxt = r_f_vld;
                end
                if (w_slot_eocc && (!r_e_vld || (w_slot_eloc > r_e_loc))) begin
                    w_e_loc_nxt = w_slot_eloc;
                    w_e_idx_nxt = r_i;
                    w_e_vld_nxt = 1'b1;
                end else begin
                    w_e_vld_nxt = r_e_vld;
                end
                if (r_i == LAST_IDX) begin
                    w_state_nxt = S_ADJUST;
                    w_i_nxt     = IDX_ZERO;
                end else begin
                    w_i_nxt     = r_i + IDX_ONE;
                end
            end
            S_ADJUST: begin
                w_f_loc_nxt = w_f_adj;
                w_e_loc_nxt = w_e_adj;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (Ack) begin
                    w_state_nxt = S_INITIAL;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_INITIAL;
                w_i_nxt     = IDX_ZERO;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INITIAL;
            r_i     <= IDX_ZERO;
            r_f_loc <= LOC_MAX;
            r_e_loc <= LOC_ZERO;
            r_f_idx <= IDX_ZERO;
            r_e_idx <= IDX_ZERO;
            r_f_vld <= 1'b0;
            r_e_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_f_loc <= w_f_loc_nxt;
            r_e_loc <= w_e_loc_nxt;
            r_f_idx <= w_f_idx_nxt;
            r_e_idx <= w_e_idx_nxt;
            r_f_vld <= w_f_vld_nxt;
            r_e_vld <= w_e_vld_nxt;
        end
    end

    assign friendlyFront = r_f_loc;
    assign enemyFront    = r_e_loc;
    assign friendlyIdx   = r_f_idx;
    assign enemyIdx      = r_e_idx;
    assign friendlyValid = r_f_vld;
    assign enemyValid    = r_e_vld;
    assign Busy          = r_state[1] | r_state[2];
    assign Done          = r_state[3];

endmodule

// File: tb/tb_battle_front_scanner.sv
// Self-checking bench for battle_front_scanner: vector table plus scoreboard, with reset and handshake sequences.
module tb_battle_front_scanner;
    localparam int NS = 16;
    localparam int LW = 9;
    localparam int TW = 2;
    localparam int IW = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic Start = 1'b0;
    logic Ack   = 1'b0;
    logic [NS*LW-1:0] unitLoc   = '0;
    logic [NS*TW-1:0] unitType  = '0;
    logic [NS*LW-1:0] enemyLoc  = '0;
    logic [NS*TW-1:0] enemyType = '0;
    logic [LW-1:0] friendlyFront, enemyFront;
    logic [IW-1:0] friendlyIdx, enemyIdx;
    logic friendlyValid, enemyValid, Busy, Done;

    typedef struct {
        logic [NS*LW-1:0] uloc;
        logic [NS*TW-1:0] utyp;
        logic [NS*LW-1:0] eloc;
        logic [NS*TW-1:0] etyp;
        logic [LW-1:0]    ff;
        logic [LW-1:0]    ef;
        logic [IW-1:0]    fi;
        logic [IW-1:0]    ei;
        logic             fv;
        logic             ev;
    } vec_t;

    vec_t tbl[7];
    vec_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    battle_front_scanner dut (
        .clk(clk), .rst(rst), .Start(Start), .Ack(Ack),
        .unitLoc(unitLoc), .unitType(unitType), .enemyLoc(enemyLoc), .enemyType(enemyType),
        .friendlyFront(friendlyFront), .enemyFront(enemyFront),
        .friendlyIdx(friendlyIdx), .enemyIdx(enemyIdx),
        .friendlyValid(friendlyValid), .enemyValid(enemyValid),
        .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.uloc = '0; v.utyp = '0; v.eloc = '0; v.etyp = '0;
        v.ff = 9'd0; v.ef = 9'd0; v.fi = 4'd0; v.ei = 4'd0; v.fv = 1'b0; v.ev = 1'b0;
        return v;
    endfunction

    function automatic vec_t put(input vec_t v, input bit enemy, input int s,
                                 input logic [LW-1:0] l, input logic [TW-1:0] t);
        if (enemy) begin
            v.eloc[s*LW +: LW] = l;
            v.etyp[s*TW +: TW] = t;
        end else begin
            v.uloc[s*LW +: LW] = l;
            v.utyp[s*TW +: TW] = t;
        end
        return v;
    endfunction

    function automatic vec_t set_exp(input vec_t v, input logic [LW-1:0] ff, input logic [IW-1:0] fi,
                                     input logic fv, input logic [LW-1:0] ef, input logic [IW-1:0] ei,
                                     input logic ev);
        v.ff = ff; v.fi = fi; v.fv = fv; v.ef = ef; v.ei = ei; v.ev = ev;
        return v;
    endfunction

    // Reference: nearest occupied slot per side (first on ties), then offsets
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.ff = 9'd511; r.ef = 9'd0; r.fi = 4'd0; r.ei = 4'd0; r.fv = 1'b0; r.ev = 1'b0;
        for (int s = 0; s < NS; s++) begin
            if (v.utyp[s*TW +: TW] != 2'd0 && (!r.fv || v.uloc[s*LW +: LW] < r.ff)) begin
                r.ff = v.uloc[s*LW +: LW]; r.fi = IW'(s); r.fv = 1'b1;
            end
            if (v.etyp[s*TW +: TW] != 2'd0 && (!r.ev || v.eloc[s*LW +: LW] > r.ef)) begin
                r.ef = v.eloc[s*LW +: LW]; r.ei = IW'(s); r.ev = 1'b1;
            end
        end
`ifdef BATTLE_FRONT_SAT_EN
        r.ff = (r.ff < 9'd6) ? 9'd0 : r.ff - 9'd6;
        r.ef = (r.ef > 9'd504) ? 9'd511 : r.ef + 9'd7;
`else
        r.ff = r.ff - 9'd6;
        r.ef = r.ef + 9'd7;
`endif
        return r;
    endfunction

    task automatic run_scan(input vec_t v, input bit keep_start);
        vec_t e;
        int edges;
        @(negedge clk);
        unitLoc = v.uloc; unitType = v.utyp; enemyLoc = v.eloc; enemyType = v.etyp;
        Start = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        chk("busy_after_start", Busy, 1);
        if (!keep_start) Start = 1'b0;
        edges = 1;
        while (Done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        Start = 1'b0;
        chk("done_latency_edges", edges, 17);
        chk("busy_in_done", Busy, 0);
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard: no expected record queued");
        end else begin
            e = sb.pop_front();
            chk("friendlyFront", friendlyFront, e.ff);
            chk("enemyFront", enemyFront, e.ef);
            chk("friendlyIdx", friendlyIdx, e.fi);
            chk("enemyIdx", enemyIdx, e.ei);
            chk("friendlyValid", friendlyValid, e.fv);
            chk("enemyValid", enemyValid, e.ev);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        Ack = 1'b1;
        @(posedge clk); #1;
        chk("done_cleared_by_ack", Done, 0);
        @(negedge clk);
        Ack = 1'b0;
    endtask

    initial begin
        // Vector table: hand-computed cases first, random cases checked against the model
        tbl[0] = set_exp(blank(), 9'd505, 4'd0, 1'b0, 9'd7, 4'd0, 1'b0);
        tbl[1] = put(put(put(put(blank(), 1'b0, 3, 9'd200, 2'd1), 1'b0, 9, 9'd150, 2'd2),
                         1'b1, 5, 9'd100, 2'd1), 1'b1, 12, 9'd120, 2'd3);
        tbl[1] = set_exp(tbl[1], 9'd144, 4'd9, 1'b1, 9'd127, 4'd12, 1'b1);
        tbl[2] = put(put(blank(), 1'b1, 2, 9'd80, 2'd1), 1'b1, 7, 9'd80, 2'd2);
        tbl[2] = set_exp(tbl[2], 9'd505, 4'd0, 1'b0, 9'd87, 4'd2, 1'b1);
        tbl[3] = put(put(blank(), 1'b0, 0, 9'd3, 2'd1), 1'b1, 0, 9'd508, 2'd2);
`ifdef BATTLE_FRONT_SAT_EN
        tbl[3] = set_exp(tbl[3], 9'd0, 4'd0, 1'b1, 9'd511, 4'd0, 1'b1);
`else
        tbl[3] = set_exp(tbl[3], 9'd509, 4'd0, 1'b1, 9'd3, 4'd0, 1'b1);
`endif
        tbl[4] = put(put(put(put(blank(), 1'b0, 4, 9'd50, 2'd1), 1'b0, 1, 9'd50, 2'd2),
                         1'b0, 15, 9'd5, 2'd0), 1'b0, 7, 9'd60, 2'd3);
        tbl[4] = put(put(put(tbl[4], 1'b1, 0, 9'd10, 2'd1), 1'b1, 15, 9'd400, 2'd3),
                     1'b1, 9, 9'd400, 2'd2);
        tbl[4] = set_exp(tbl[4], 9'd44, 4'd1, 1'b1, 9'd407, 4'd9, 1'b1);
        for (int k = 5; k < 7; k++) begin
            tbl[k] = blank();
            for (int s = 0; s < NS; s++) begin
                tbl[k] = put(tbl[k], 1'b0, s, LW'($urandom_range(510, 1)), TW'($urandom_range(3, 0)));
                tbl[k] = put(tbl[k], 1'b1, s, LW'($urandom_range(510, 1)), TW'($urandom_range(3, 0)));
            end
            tbl[k] = model(tbl[k]);
        end

        // Reset values while rst is held low
        @(posedge clk); #1;
        chk("rst_friendlyFront", friendlyFront, 511);
        chk("rst_enemyFront", enemyFront, 0);
        chk("rst_idx", {friendlyIdx, enemyIdx}, 0);
        chk("rst_valid", {friendlyValid, enemyValid}, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start_busy", Busy, 0);

        for (int k = 0; k < 7; k++) begin
            run_scan(tbl[k], k == 1);
            do_ack();
        end

        // Asynchronous reset during the fifth scan cycle
        @(negedge clk);
        unitLoc = tbl[1].uloc; unitType = tbl[1].utyp; enemyLoc = tbl[1].eloc; enemyType = tbl[1].etyp;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midscan_rst_busy", Busy, 0);
        chk("midscan_rst_done", Done, 0);
        chk("midscan_rst_friendlyFront", friendlyFront, 511);
        chk("midscan_rst_enemyFront", enemyFront, 0);
        chk("midscan_rst_valid", {friendlyValid, enemyValid}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_no_done", Done, 0);
        chk("post_rst_no_busy", Busy, 0);

        // Hold DONE with Start high and no Ack, then Ack and Start together
        run_scan(tbl[1], 1'b0);
        @(negedge clk);
        Start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_done", Done, 1);
            chk("hold_friendlyFront", friendlyFront, tbl[1].ff);
            chk("hold_enemyFront", enemyFront, tbl[1].ef);
        end
        @(negedge clk);
        Ack = 1'b1;
        @(posedge clk); #1;
        chk("ack_start_done", Done, 0);
        chk("ack_start_busy", Busy, 0);
        @(negedge clk);
        Ack = 1'b0;
        Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_scan_without_start", Busy, 0);
        run_scan(tbl[2], 1'b0);
        do_ack();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
